dct_coeff_mac: RTL and testbench

- Streaming multiply-accumulate stage that computes one 2-D DCT coefficient per 8x8 pixel block.
- Pixels arrive in raster order. The block drives the (n1, n2) index to an external combinational cosine LUT for a fixed (k1, k2). It multiplies each level-shifted pixel by the returned cosine term and accumulates over 64 pixels.
- Emits a rounded, normalised, saturated coefficient through a valid/ready handshake.
- Sits directly downstream of the per-coefficient cosine LUTs and upstream of coefficient storage or quantisation.

---
 rtl/dct_pkg.sv | 15 +
 rtl/dct_round_sat.sv | 35 +++
 rtl/dct_coeff_mac.sv | 143 ++++++++++++++
 tb/tb_dct_coeff_mac.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the 8x8 DCT coefficient MAC.
package dct_pkg;

    localparam int BLOCK_DIM     = 8;
    localparam int BLOCK_PIXELS  = 64;
    localparam int LEVEL_SHIFT   = 128;
    localparam int COS_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } dct_mac_state_t;

endpackage

// File: rtl/dct_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation from ACC_W to OUT_W.
module dct_round_sat #(
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 10
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] coeff
);

    localparam int HALF_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] HALF =
        (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << HALF_POS) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One guard bit so adding the rounding constant cannot wrap.
    always_comb begin
        biased  = {sum[ACC_W-1], sum} + HALF;
        shifted = biased >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            coeff = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            coeff = SAT_MIN[OUT_W-1:0];
        end else begin
            coeff = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dct_coeff_mac.sv
// Streams an 8x8 block against an external cosine LUT and emits one rounded,
// saturated DCT coefficient per block over a valid/ready handshake.
//
// state | meaning
// ACCUM | accepting pixels, accumulating registered products
// DRAIN | last product in prod_q; form, round and register the coefficient
// OUT   | coefficient held until the consumer takes it
module dct_coeff_mac
    import dct_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int COS_W     = 32,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [PIX_W-1:0]        pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic [2:0]              n1,
    output logic [2:0]              n2,
    input  logic signed [COS_W-1:0] cos_term,
    output logic signed [OUT_W-1:0] coeff_out,
    output logic                    coeff_valid,
    input  logic                    coeff_ready
);

    dct_mac_state_t state, state_nxt;

    logic [5:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_q;
    logic                    prod_v;

    logic                    accept;
    logic                    last_pix;
    logic [PIX_W-1:0]        pix_shift;
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] cos_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] coeff_rs;

    assign pixel_ready = (state == ACCUM) && !rst;
    assign accept      = pixel_valid && pixel_ready;
    assign last_pix    = (cnt == 6'(BLOCK_PIXELS - 1));
    assign n1          = cnt[5:3];
    assign n2          = cnt[2:0];

    // Only the low ACC_W bits of the product are kept, so multiply at ACC_W.
    assign pix_shift = pixel_in - PIX_W'(LEVEL_SHIFT);
    assign pix_ext   = ACC_W'($signed(pix_shift));
    assign cos_ext   = ACC_W'(cos_term);
    assign prod      = pix_ext * cos_ext;
    assign sum       = acc + prod_q;

    dct_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .sum   (sum),
        .coeff (coeff_rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (flush) begin
                    state_nxt = ACCUM;
                end else if (accept && last_pix) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = flush ? ACCUM : OUT;
            OUT: begin
                if (coeff_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            prod_q      <= '0;
            prod_v      <= 1'b0;
            coeff_out   <= '0;
            coeff_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (flush) begin
                        cnt    <= '0;
                        acc    <= '0;
                        prod_v <= 1'b0;
                    end else begin
                        if (prod_v) begin
                            acc <= acc + prod_q;
                        end
                        prod_v <= accept;
                        if (accept) begin
                            prod_q <= prod;
                            cnt    <= cnt + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    acc    <= '0;
                    prod_v <= 1'b0;
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        coeff_out   <= coeff_rs;
                        coeff_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (coeff_ready) begin
                        coeff_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coeff_mac.sv
// Directed bench for dct_coeff_mac with the (k1=2, k2=2) cosine LUT modelled locally.
module tb_dct_coeff_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [7:0]         pixel_in;
    logic               pixel_valid;
    logic               coeff_ready;

    logic               pixel_ready, pixel_ready_s;
    logic [2:0]         n1, n2, n1_s, n2_s;
    logic signed [31:0] cos_term, cos_term_s;
    logic signed [15:0] coeff_out, coeff_out_s;
    logic               coeff_valid, coeff_valid_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 256*cos((2n1+1)pi/8)*cos((2n2+1)pi/8), truncated toward zero.
    function automatic logic signed [31:0] lut22(input logic [2:0] a, input logic [2:0] b);
        bit big_a, big_b, neg_a, neg_b;
        int mag;
        big_a = (a == 3'd0) || (a == 3'd3) || (a == 3'd4) || (a == 3'd7);
        big_b = (b == 3'd0) || (b == 3'd3) || (b == 3'd4) || (b == 3'd7);
        neg_a = (a >= 3'd2) && (a <= 3'd5);
        neg_b = (b >= 3'd2) && (b <= 3'd5);
        if (big_a && big_b)        mag = 218;
        else if (!big_a && !big_b) mag = 37;
        else                       mag = 90;
        return (neg_a ^ neg_b) ? -mag : mag;
    endfunction

    assign cos_term   = lut22(n1, n2);
    assign cos_term_s = lut22(n1_s, n2_s);

    dct_coeff_mac #(.OUT_SHIFT(10)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .n1(n1), .n2(n2), .cos_term(cos_term),
        .coeff_out(coeff_out), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready)
    );

    dct_coeff_mac #(.OUT_SHIFT(0)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready_s),
        .n1(n1_s), .n2(n2_s), .cos_term(cos_term_s),
        .coeff_out(coeff_out_s), .coeff_valid(coeff_valid_s), .coeff_ready(coeff_ready)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: flat 128, 1: sign-matched, 2: inverted, 3: all 255
    function automatic logic [7:0] pix_val(input int mode, input int idx);
        logic signed [31:0] c;
        c = lut22(3'(idx >> 3), 3'(idx & 7));
        case (mode)
            0:       return 8'd128;
            1:       return (c > 0) ? 8'd228 : 8'd28;
            2:       return (c > 0) ? 8'd28 : 8'd228;
            default: return 8'd255;
        endcase
    endfunction

    task automatic send_pixels(input int mode, input int count, input bit stall);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        bit  stalled63 = 0;
        while (i < count && guard < 1000) begin
            @(negedge clk);
            if (stall) begin
                chk("stall_n1", 32'(n1), 32'((i >> 3) & 7));
                chk("stall_n2", 32'(n2), 32'(i & 7));
            end
            if (stall && ((i == 63 && !stalled63) || $urandom_range(0, 2) == 0)) begin
                if (i == 63) stalled63 = 1;
                pixel_valid = 1'b0;
                pixel_in    = 8'hxx;
            end else begin
                pixel_valid = 1'b1;
                pixel_in    = pix_val(mode, i);
            end
            acc = pixel_valid && pixel_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        chk("send_count", i, count);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!coeff_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(coeff_valid), 1);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        coeff_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        coeff_ready = 1'b0;
        chk({tag, "_vld0"}, 32'(coeff_valid), 0);
        chk({tag, "_rdy1"}, 32'(pixel_ready), 1);
    endtask

    task automatic block_check(input int mode, input bit stall, input int exp, input int exp_sat, input string tag);
        send_pixels(mode, 64, stall);
        @(negedge clk);
        pixel_valid = 1'b0;
        wait_valid({tag, "_valid"});
        chk({tag, "_coeff"}, 32'(coeff_out), exp);
        chk({tag, "_sat"}, 32'(coeff_out_s), exp_sat);
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pixel_in = 8'd0; pixel_valid = 1'b0; coeff_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(coeff_valid), 0);
        chk("rst_coeff", 32'(coeff_out), 0);
        chk("rst_n1", 32'(n1), 0);
        chk("rst_n2", 32'(n2), 0);
        chk("rst_ready", 32'(pixel_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(pixel_ready), 1);

        // flat block and exact two-cycle latency
        send_pixels(0, 64, 0);
        @(negedge clk);
        pixel_valid = 1'b0;
        chk("flat_lat_t1", 32'(coeff_valid), 0);
        chk("flat_ready_drain", 32'(pixel_ready), 0);
        @(negedge clk);
        chk("flat_lat_t2", 32'(coeff_valid), 1);
        chk("flat_coeff", 32'(coeff_out), 0);
        chk("flat_sat", 32'(coeff_out_s), 0);
        handshake("flat");

        block_check(1, 0, 680, 32767, "match");
        block_check(2, 0, -680, -32768, "inv");

        // backpressure, plus flush in OUT must not drop the coefficient
        send_pixels(1, 64, 0);
        @(negedge clk);
        pixel_valid = 1'b0;
        wait_valid("bp_valid");
        for (int c = 0; c < 5; c++) begin
            chk("bp_coeff", 32'(coeff_out), 680);
            chk("bp_valid_hold", 32'(coeff_valid), 1);
            chk("bp_ready0", 32'(pixel_ready), 0);
            flush = (c == 2);
            @(negedge clk);
        end
        flush = 1'b0;
        chk("bp_after_flush", 32'(coeff_valid), 1);
        coeff_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        coeff_ready = 1'b0;
        chk("bp_ready1", 32'(pixel_ready), 1);
        chk("bp_n1", 32'(n1), 0);
        chk("bp_n2", 32'(n2), 0);
        chk("bp_vld0", 32'(coeff_valid), 0);

        // flush mid-block, colliding with an accept
        send_pixels(3, 30, 0);
        @(negedge clk);
        flush = 1'b1;
        pixel_valid = 1'b1;
        pixel_in = 8'd255;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        pixel_valid = 1'b0;
        chk("flush_n1", 32'(n1), 0);
        chk("flush_n2", 32'(n2), 0);
        chk("flush_vld", 32'(coeff_valid), 0);
        block_check(1, 0, 680, 32767, "flush");

        // reset mid-block
        send_pixels(3, 30, 0);
        @(negedge clk);
        pixel_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_n1", 32'(n1), 0);
        chk("mrst_n2", 32'(n2), 0);
        chk("mrst_ready", 32'(pixel_ready), 0);
        chk("mrst_valid", 32'(coeff_valid), 0);
        chk("mrst_coeff", 32'(coeff_out), 0);
        rst = 1'b0;
        block_check(1, 0, 680, 32767, "mrst");

        // random stalls, including across pixel 63
        block_check(1, 1, 680, 32767, "stall");
        block_check(2, 1, -680, -32768, "stall_inv");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
